// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// APB initiator bridging a request/response command port to four APB slaves
// (slot 0 GPI, 1 GPO, 2 UART, 3 timer). Each accepted command becomes one
// SETUP + ACCESS transfer to the slave decoded from the address. Unmapped
// addresses and slaves that never raise PREADY are answered with an error
// response.
//
// Address map: 0x1000_0000 - 0x1000_3FFF, 4 KiB per slave, slave = addr[13:12].
//
// Ports
//   PCLK, PRESET          clock (rising edge), async active-high reset
//   req, req_addr,        command valid, byte address,
//   req_write, req_wdata  direction (1 = write), write data
//   req_ready             command accepted on req && req_ready at an edge
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata, rsp_err    read data (0 on write/error), error flag; both
//                         hold until the next rsp_valid
//   PADDR, PWRITE,        APB address, direction,
//   PWDATA, PENABLE, PSEL write data, access phase, one-hot select
//   PRDATAn, PREADYn      per-slave read data and ready (n = 0..3)
//
// Parameter
//   TIMEOUT               ACCESS cycles waited for PREADY before aborting (>= 2)
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a command; decode address on acceptance
// SETUP  | APB setup phase (PSEL high, PENABLE low), lasts one cycle
// ACCESS | APB access phase, waiting for the selected PREADY or timeout
// ERR    | one-cycle error path for unmapped addresses, no APB activity
// ---------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,

  input  logic        req,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,

  output logic [31:0] PADDR,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic        PENABLE,
  output logic [3:0]  PSEL,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [17:0] MAP_BASE = 18'h04000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t           state_q,     state_d;
  logic [1:0]       sel_q,       sel_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [31:0]      paddr_q,     paddr_d;
  logic             pwrite_q,    pwrite_d;
  logic [31:0]      pwdata_q,    pwdata_d;
  logic             penable_q,   penable_d;
  logic [3:0]       psel_q,      psel_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q,   rsp_err_d;

  logic             addr_hit;
  logic             pready_sel;
  logic [31:0]      prdata_sel;

  assign addr_hit = (req_addr[31:14] == MAP_BASE);

  // Only the addressed slave's PREADY/PRDATA are looked at.
  always_comb begin
    pready_sel = 1'b0;
    prdata_sel = '0;
    case (sel_q)
      2'd0: begin pready_sel = PREADY0; prdata_sel = PRDATA0; end
      2'd1: begin pready_sel = PREADY1; prdata_sel = PRDATA1; end
      2'd2: begin pready_sel = PREADY2; prdata_sel = PRDATA2; end
      default: begin pready_sel = PREADY3; prdata_sel = PRDATA3; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    penable_d   = penable_q;
    psel_d      = psel_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (addr_hit) begin
            // APB bus values only change for mapped commands, so an
            // unmapped request leaves the last transfer visible on PADDR.
            state_d   = S_SETUP;
            sel_d     = req_addr[13:12];
            cnt_d     = '0;
            paddr_d   = req_addr;
            pwrite_d  = req_write;
            pwdata_d  = req_wdata;
            psel_d    = 4'b0001 << req_addr[13:12];
            penable_d = 1'b0;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end

      S_ACCESS: begin
        if (pready_sel) begin
          state_d     = S_IDLE;
          psel_d      = 4'b0000;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? 32'h0 : prdata_sel;
        end else if (cnt_q == CNT_LAST) begin
          // cnt_q counts completed wait cycles, so this is the end of the
          // TIMEOUT-th ACCESS cycle; a PREADY here would have won above.
          state_d     = S_IDLE;
          psel_d      = 4'b0000;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ERR: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = 32'h0;
      end

      default: begin
        state_d   = S_IDLE;
        psel_d    = 4'b0000;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= S_IDLE;
      sel_q       <= 2'd0;
      cnt_q       <= '0;
      paddr_q     <= 32'h0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= 32'h0;
      penable_q   <= 1'b0;
      psel_q      <= 4'b0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      penable_q   <= penable_d;
      psel_q      <= psel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PENABLE   = penable_q;
  assign PSEL      = psel_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PENABLE;
  logic [3:0]  PSEL;
  logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
  logic        PREADY0, PREADY1, PREADY2, PREADY3;

  int n_total = 0;
  int n_pass  = 0;

  apb_master_bridge #(.TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req(req), .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL),
    .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
    .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Present a command from the falling edge, let the next rising edge take
  // it, and leave the bench 1 time unit after that accept edge.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d);
    @(negedge PCLK);
    req = 1'b1; req_addr = a; req_write = w; req_wdata = d;
    @(posedge PCLK); #1;
    req = 1'b0;
  endtask

  task automatic step();
    @(posedge PCLK); #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET = 1'b1;
    req = 1'b1; req_addr = 32'h1000_0000; req_write = 1'b1; req_wdata = 32'hFFFF_FFFF;
    PRDATA0 = 32'h0BAD_0000; PRDATA1 = 32'h0BAD_0001; PRDATA2 = 32'h0000_00A5; PRDATA3 = 32'h0000_1234;
    PREADY0 = 1'b1; PREADY1 = 1'b1; PREADY2 = 1'b0; PREADY3 = 1'b0;

    // Reset state, with a request held during reset that must be discarded
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_psel",      PSEL,      32'h0);
    chk("rst_penable",   PENABLE,   32'h0);
    chk("rst_paddr",     PADDR,     32'h0);
    chk("rst_pwrite",    PWRITE,    32'h0);
    chk("rst_pwdata",    PWDATA,    32'h0);
    chk("rst_rsp_valid", rsp_valid, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err",   rsp_err,   32'h0);
    chk("rst_req_ready", req_ready, 32'h1);
    @(negedge PCLK);
    req = 1'b0;
    PRESET = 1'b0;
    step();
    chk("post_rst_psel", PSEL, 32'h0);

    // Zero-wait write to slave 0
    issue(32'h1000_0000, 1'b1, 32'h0000_00FF);
    chk("w0_setup_psel",    PSEL,      32'h1);
    chk("w0_setup_penable", PENABLE,   32'h0);
    chk("w0_setup_pwdata",  PWDATA,    32'hFF);
    chk("w0_setup_paddr",   PADDR,     32'h1000_0000);
    chk("w0_setup_pwrite",  PWRITE,    32'h1);
    chk("w0_setup_ready",   req_ready, 32'h0);
    step();
    chk("w0_acc_psel",      PSEL,      32'h1);
    chk("w0_acc_penable",   PENABLE,   32'h1);
    chk("w0_acc_pwdata",    PWDATA,    32'hFF);
    chk("w0_acc_rsp_valid", rsp_valid, 32'h0);
    step();
    chk("w0_rsp_valid",     rsp_valid, 32'h1);
    chk("w0_rsp_err",       rsp_err,   32'h0);
    chk("w0_rsp_rdata",     rsp_rdata, 32'h0);
    chk("w0_idle_psel",     PSEL,      32'h0);
    chk("w0_idle_penable",  PENABLE,   32'h0);
    chk("w0_hold_paddr",    PADDR,     32'h1000_0000);
    step();
    chk("w0_pulse_end",     rsp_valid, 32'h0);

    // Read slave 2 with 3 wait states, PREADY0 toggling meanwhile
    PREADY2 = 1'b0;
    issue(32'h1000_2004, 1'b0, 32'h0);
    chk("r2_setup_psel",    PSEL,    32'h4);
    chk("r2_setup_penable", PENABLE, 32'h0);
    chk("r2_setup_pwrite",  PWRITE,  32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("r2_acc%0d_penable", i), PENABLE,   32'h1);
      chk($sformatf("r2_acc%0d_psel", i),    PSEL,      32'h4);
      chk($sformatf("r2_acc%0d_valid", i),   rsp_valid, 32'h0);
      PREADY0 = ~PREADY0;
      PREADY2 = (i == 3);
    end
    step();
    chk("r2_rsp_valid", rsp_valid, 32'h1);
    chk("r2_rsp_rdata", rsp_rdata, 32'h0000_00A5);
    chk("r2_rsp_err",   rsp_err,   32'h0);
    chk("r2_idle_psel", PSEL,      32'h0);
    PREADY2 = 1'b0;
    PREADY0 = 1'b1;
    step();
    chk("r2_hold_rdata", rsp_rdata, 32'h0000_00A5);

    // Unmapped read
    issue(32'h2000_0000, 1'b0, 32'h0);
    chk("um_err_psel",  PSEL,      32'h0);
    chk("um_err_ready", req_ready, 32'h0);
    chk("um_err_valid", rsp_valid, 32'h0);
    step();
    chk("um_rsp_valid", rsp_valid, 32'h1);
    chk("um_rsp_err",   rsp_err,   32'h1);
    chk("um_rsp_rdata", rsp_rdata, 32'h0);
    chk("um_psel",      PSEL,      32'h0);
    chk("um_paddr",     PADDR,     32'h1000_2004);

    // Timeout on slave 3: exactly 16 ACCESS cycles
    issue(32'h1000_3000, 1'b0, 32'h0);
    chk("to_setup_psel", PSEL, 32'h8);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("to_acc%0d_penable", i), PENABLE,   32'h1);
      chk($sformatf("to_acc%0d_valid", i),   rsp_valid, 32'h0);
    end
    step();
    chk("to_rsp_valid", rsp_valid, 32'h1);
    chk("to_rsp_err",   rsp_err,   32'h1);
    chk("to_rsp_rdata", rsp_rdata, 32'h0);
    chk("to_psel",      PSEL,      32'h0);
    chk("to_penable",   PENABLE,   32'h0);

    // PREADY3 first seen in the 16th ACCESS cycle still succeeds
    issue(32'h1000_3000, 1'b0, 32'h0);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk($sformatf("to16_acc%0d_penable", i), PENABLE, 32'h1);
      if (i == 16) PREADY3 = 1'b1;
    end
    step();
    chk("to16_rsp_valid", rsp_valid, 32'h1);
    chk("to16_rsp_err",   rsp_err,   32'h0);
    chk("to16_rsp_rdata", rsp_rdata, 32'h0000_1234);
    PREADY3 = 1'b0;

    // Back-to-back: write slave 1 then read slave 0, req held high
    PREADY0 = 1'b1; PREADY1 = 1'b1; PRDATA0 = 32'h5555_AAAA;
    @(negedge PCLK);
    req = 1'b1; req_addr = 32'h1000_1008; req_write = 1'b1; req_wdata = 32'hCAFE_0001;
    step();
    chk("bb1_setup_psel", PSEL, 32'h2);
    req_addr = 32'h1000_0010; req_write = 1'b0; req_wdata = 32'h0;
    step();
    chk("bb1_acc_penable", PENABLE, 32'h1);
    chk("bb1_acc_pwdata",  PWDATA,  32'hCAFE_0001);
    chk("bb1_acc_pwrite",  PWRITE,  32'h1);
    step();
    chk("bb1_rsp_valid", rsp_valid, 32'h1);
    chk("bb1_rsp_err",   rsp_err,   32'h0);
    chk("bb1_rsp_rdata", rsp_rdata, 32'h0);
    chk("bb1_req_ready", req_ready, 32'h1);
    step();
    req = 1'b0;
    chk("bb2_setup_psel",    PSEL,      32'h1);
    chk("bb2_setup_penable", PENABLE,   32'h0);
    chk("bb2_setup_paddr",   PADDR,     32'h1000_0010);
    chk("bb2_setup_pwrite",  PWRITE,    32'h0);
    chk("bb2_setup_valid",   rsp_valid, 32'h0);
    step();
    chk("bb2_acc_penable", PENABLE, 32'h1);
    step();
    chk("bb2_rsp_valid", rsp_valid, 32'h1);
    chk("bb2_rsp_err",   rsp_err,   32'h0);
    chk("bb2_rsp_rdata", rsp_rdata, 32'h5555_AAAA);
    step();
    chk("bb2_pulse_end", rsp_valid, 32'h0);

    // Reset asserted during ACCESS drops the transfer
    PREADY0 = 1'b0;
    issue(32'h1000_0004, 1'b1, 32'h0000_0077);
    step();
    chk("mr_acc_penable", PENABLE, 32'h1);
    #2;
    PRESET = 1'b1;
    #1;
    chk("mr_async_psel",    PSEL,    32'h0);
    chk("mr_async_penable", PENABLE, 32'h0);
    PREADY0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mr_rst%0d_valid", i), rsp_valid, 32'h0);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    step();
    chk("mr_post_valid", rsp_valid, 32'h0);
    chk("mr_post_paddr", PADDR,     32'h0);
    issue(32'h1000_0008, 1'b1, 32'h0000_0099);
    chk("mr_w_setup_psel",   PSEL,   32'h1);
    chk("mr_w_setup_pwdata", PWDATA, 32'h99);
    step();
    chk("mr_w_acc_penable", PENABLE, 32'h1);
    step();
    chk("mr_w_rsp_valid", rsp_valid, 32'h1);
    chk("mr_w_rsp_err",   rsp_err,   32'h0);
    chk("mr_w_rsp_rdata", rsp_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB initiator that turns a simple request/response command port into APB transfers and routes them to one of four APB peripherals (GPI, GPO, UART, timer slots). It sits between the CPU-side bus logic and the peripheral slaves, generating SETUP/ACCESS phases, decoding PSEL, muxing PRDATA/PREADY back, and guarding against hung slaves with a wait-state timeout.

## Interface
- TIMEOUT, 16, max ACCESS cycles waited for PREADY before aborting (≥2)
- PCLK  in  1  APB clock; all logic on rising edge
- PRESET  in  1  reset, asynchronous, active-high
- req  in  1  command valid
- req_addr  in  32  byte address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  32  write data
- req_ready  out  1  command accepted when req && req_ready at a rising edge
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data (0 for writes and errors)
- rsp_err  out  1  valid with rsp_valid; 1 = unmapped address or timeout
- PADDR  out  32  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  32  APB write data
- PENABLE  out  1  APB access phase
- PSEL  out  4  one-hot slave select
- PRDATA0..PRDATA3  in  32 each  slave read data
- PREADY0..PREADY3  in  1 each  slave ready

## Operation
- Map: slave n = addr[13:12] when addr[31:14] == 18'h04000 (0x1000_0000–0x1000_3FFF, 4 KiB each); anything else unmapped.
- States: IDLE, SETUP, ACCESS, ERR.
- IDLE: req_ready = 1 (combinational from state). On acceptance latch addr/write/wdata and slave index; mapped → SETUP, unmapped → ERR (no APB activity).
- SETUP: PSEL[n] = 1, PENABLE = 0, PADDR/PWRITE/PWDATA = latched values. Unconditionally → ACCESS next cycle.
- ACCESS: PSEL[n] = 1, PENABLE = 1, address/control/data held stable. Only PREADY[n]/PRDATA[n] of selected slave observed; others ignored.
  - PREADY[n] = 1 at an edge → IDLE; rsp_valid = 1 next cycle, rsp_err = 0, rsp_rdata = PRDATA[n] for reads, 0 for writes.
  - TIMEOUT consecutive ACCESS cycles without PREADY[n] → IDLE; rsp_valid = 1, rsp_err = 1, rsp_rdata = 0. PREADY in the TIMEOUT-th cycle counts as success.
- ERR: one cycle; → IDLE with rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- Wait-state counter clears on entry to SETUP; width $clog2(TIMEOUT+1).
- Outside SETUP/ACCESS: PSEL = 0, PENABLE = 0; PADDR/PWRITE/PWDATA keep last values.
- rsp_rdata/rsp_err hold until next rsp_valid.

## Timing
- All APB outputs and rsp_* registered.
- Reset: state IDLE, PSEL = 0, PENABLE = 0, PADDR = 0, PWRITE = 0, PWDATA = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0. Requests presented while PRESET high are discarded.
- Zero-wait slave: accept edge T; SETUP cycle T..T+1; ACCESS T+1..T+2; rsp_valid high T+2..T+3 (3 cycles). Each wait state adds 1.
- Slave that registers PREADY one cycle after PSEL&&PENABLE: 2 ACCESS cycles, rsp_valid 4 cycles after accept.
- Unmapped: rsp_valid high 2 cycles after accept edge (through ERR).
- Back-to-back: req_ready is high in the cycle rsp_valid is high; a new request may be accepted then, and its SETUP starts the next cycle (no idle gap required).
- Reset mid-transfer: PSEL/PENABLE drop asynchronously, no rsp_valid issued, transaction dropped.

## Test plan
- Write 0x0000_00FF to 0x1000_0000, slave0 PREADY held high → PSEL=4'b0001 one SETUP + one ACCESS cycle, PWDATA=0xFF stable both, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read 0x1000_2004, slave2 asserts PREADY after 3 wait states with PRDATA2=0xA5 → PSEL=4'b0100, PENABLE high 4 cycles, rsp_rdata=0x0000_00A5, rsp_err=0; PREADY0 toggling meanwhile has no effect.
- Read 0x2000_0000 → no PSEL bit ever set, rsp_valid 2 cycles after accept, rsp_err=1, rsp_rdata=0.
- Read 0x1000_3000, PREADY3 never asserted, TIMEOUT=16 → exactly 16 ACCESS cycles, then PSEL=0, rsp_err=1, rsp_rdata=0; repeat with PREADY3 first high in 16th cycle → rsp_err=0.
- Two back-to-back requests (write slave1, read slave0), req held high → second accepted in the cycle rsp_valid of first is high; SETUP of second immediately follows; both responses correct.
- Assert PRESET during ACCESS → PSEL/PENABLE 0 before next edge, no rsp_valid; after release, a fresh write completes normally.
